// File: rtl/commit_watch_monitor_pkg.sv
// Shared types and constants for the commit watch monitor: snapshot entry
// layout, watchdog state encoding and a saturating counter helper.
package monitor_pkg;

    localparam int MON_NUM_CH = 4;
    localparam int MON_XLEN   = 32;
    localparam int MON_CNT_W  = 32;
    localparam int CH_W       = $clog2(MON_NUM_CH);

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [MON_XLEN-1:0]  data;
        logic [MON_CNT_W-1:0] seq;
    } snap_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RUN  = 2'd1,
        W_HUNG = 2'd2
    } wdog_state_t;

    // Increment when enabled, but stick at all-ones instead of wrapping.
    function automatic logic [MON_CNT_W-1:0] sat_inc(input logic [MON_CNT_W-1:0] value,
                                                    input logic                 en);
        if (en && (value != {MON_CNT_W{1'b1}})) begin
            return value + {{(MON_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/commit_watch_monitor_snap_fifo.sv
// Synchronous snapshot FIFO. Occupancy is tracked with a count register so
// full/empty never depend on pointer comparison; pointers wrap modulo DEPTH.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module snap_fifo
    import monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push_i,
    input  snap_t                  entry_i,
    input  logic                   pop_i,
    output snap_t                  head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    snap_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Next occupancy from accepted push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset and clear both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (reset && !clear && push_ok_s) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/commit_watch_monitor.sv
// Run-time observer for the out-of-order core: statistics counters, a commit
// watchdog, and per-channel mispredict-triggered register captures queued in
// a snapshot FIFO.
module commit_watch_monitor
    import monitor_pkg::*;
#(
    parameter int NUM_CH = MON_NUM_CH,
    parameter int ARCH_W = 5,
    parameter int XLEN   = MON_XLEN,
    parameter int PC_W   = 32,
    parameter int CNT_W  = MON_CNT_W,
    parameter int WDOG_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic                      cfg_en,
    input  logic [PC_W-1:0]           cfg_pc,
    input  logic [ARCH_W-1:0]         cfg_arch,
    input  logic [WDOG_W-1:0]         wdog_limit,
    input  logic                      commit_valid,
    input  logic                      mispredict,
    input  logic [PC_W-1:0]           mispredict_pc,
    output logic [NUM_CH*ARCH_W-1:0]  watch_arch,
    input  logic [NUM_CH*XLEN-1:0]    watch_data,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [$clog2(NUM_CH)-1:0] snap_ch,
    output logic [XLEN-1:0]           snap_data,
    output logic [CNT_W-1:0]          snap_seq,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [CNT_W-1:0]          commit_cnt,
    output logic [CNT_W-1:0]          mispredict_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      overflow,
    output logic                      hang
);

    logic [NUM_CH-1:0] en_q;
    logic [PC_W-1:0]   pc_q   [NUM_CH];
    logic [ARCH_W-1:0] arch_q [NUM_CH];

    logic [CNT_W-1:0]  cycle_cnt_q, commit_cnt_q, mispredict_cnt_q, drop_cnt_q;
    logic              overflow_q;

    wdog_state_t       wd_state_q, wd_state_d;
    logic [WDOG_W-1:0] idle_cnt_q, idle_cnt_d;

    logic              hit_s;
    logic [CH_W-1:0]   hit_ch_s;
    logic [XLEN-1:0]   hit_data_s;
    snap_t             push_entry_s;
    snap_t             head_s;
    logic              fifo_full_s, fifo_empty_s, pop_s, drop_s, head_live_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_watch_arch
        assign watch_arch[g*ARCH_W +: ARCH_W] = arch_q[g];
    end

    // Channel configuration: only reset wipes it, clear leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en_q <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                pc_q[i]   <= {PC_W{1'b0}};
                arch_q[i] <= {ARCH_W{1'b0}};
            end
        end else if (cfg_we) begin
            en_q[cfg_ch]   <= cfg_en;
            pc_q[cfg_ch]   <= cfg_pc;
            arch_q[cfg_ch] <= cfg_arch;
        end
    end

    // Lowest-numbered enabled channel whose trigger PC matches wins the push.
    always_comb begin
        hit_s      = 1'b0;
        hit_ch_s   = {CH_W{1'b0}};
        hit_data_s = {XLEN{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mispredict && en_q[i] && (pc_q[i] == mispredict_pc)) begin
                hit_s      = 1'b1;
                hit_ch_s   = CH_W'(i);
                hit_data_s = watch_data[i*XLEN +: XLEN];
            end else begin
                hit_s      = hit_s;
            end
        end
    end

    assign push_entry_s = '{ch: hit_ch_s, data: hit_data_s, seq: mispredict_cnt_q};
    assign pop_s        = snap_valid && snap_ready;
    assign drop_s       = hit_s && fifo_full_s && !pop_s;

    snap_fifo #(.DEPTH(DEPTH)) u_snap_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push_i  (hit_s),
        .entry_i (push_entry_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Head fields read zero whenever nothing is queued (including after reset).
    assign head_live_s = (fifo_count_s != {($clog2(DEPTH)+1){1'b0}});
    assign snap_valid  = !fifo_empty_s;
    assign snap_ch     = head_live_s ? head_s.ch   : {CH_W{1'b0}};
    assign snap_data   = head_live_s ? head_s.data : {XLEN{1'b0}};
    assign snap_seq    = head_live_s ? head_s.seq  : {CNT_W{1'b0}};

    // Saturating statistics and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cycle_cnt_q      <= {CNT_W{1'b0}};
            commit_cnt_q     <= {CNT_W{1'b0}};
            mispredict_cnt_q <= {CNT_W{1'b0}};
            drop_cnt_q       <= {CNT_W{1'b0}};
            overflow_q       <= 1'b0;
        end else begin
            cycle_cnt_q      <= sat_inc(cycle_cnt_q, 1'b1);
            commit_cnt_q     <= sat_inc(commit_cnt_q, commit_valid);
            mispredict_cnt_q <= sat_inc(mispredict_cnt_q, mispredict);
            drop_cnt_q       <= sat_inc(drop_cnt_q, drop_s);
            overflow_q       <= overflow_q | drop_s;
        end
    end

    assign cycle_cnt      = cycle_cnt_q;
    assign commit_cnt     = commit_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
    assign drop_cnt       = drop_cnt_q;
    assign overflow       = overflow_q;

    // Watchdog next state: arm on first commit, expire after wdog_limit idle cycles.
    always_comb begin
        wd_state_d = wd_state_q;
        idle_cnt_d = idle_cnt_q;
        case (wd_state_q)
            W_IDLE: begin
                idle_cnt_d = {WDOG_W{1'b0}};
                if (commit_valid) begin
                    wd_state_d = W_RUN;
                end else begin
                    wd_state_d = W_IDLE;
                end
            end
            W_RUN: begin
                if (commit_valid) begin
                    idle_cnt_d = {WDOG_W{1'b0}};
                end else if ((wdog_limit != {WDOG_W{1'b0}}) &&
                             (idle_cnt_q == (wdog_limit - WDOG_W'(1)))) begin
                    wd_state_d = W_HUNG;
                end else if (idle_cnt_q != {WDOG_W{1'b1}}) begin
                    idle_cnt_d = idle_cnt_q + WDOG_W'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            W_HUNG: begin
                wd_state_d = W_HUNG;
            end
            default: begin
                wd_state_d = W_IDLE;
                idle_cnt_d = {WDOG_W{1'b0}};
            end
        endcase
    end

    // Watchdog state register.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wd_state_q <= W_IDLE;
            idle_cnt_q <= {WDOG_W{1'b0}};
        end else begin
            wd_state_q <= wd_state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign hang = (wd_state_q == W_HUNG);

endmodule

// File: tb/tb_commit_watch_monitor.sv
// Bench for commit_watch_monitor: a queue-based behavioural model checked
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_commit_watch_monitor;

    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset, clear, cfg_we, cfg_en;
    logic [1:0]   cfg_ch;
    logic [31:0]  cfg_pc;
    logic [4:0]   cfg_arch;
    logic [15:0]  wdog_limit;
    logic         commit_valid, mispredict;
    logic [31:0]  mispredict_pc;
    logic [19:0]  watch_arch;
    logic [127:0] watch_data;
    logic         snap_valid, snap_ready;
    logic [1:0]   snap_ch;
    logic [31:0]  snap_data, snap_seq;
    logic [31:0]  cycle_cnt, commit_cnt, mispredict_cnt, drop_cnt;
    logic         overflow, hang;

    int total = 0;
    int bad   = 0;

    commit_watch_monitor dut (
        .clk(clk), .reset(reset), .clear(clear),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_pc(cfg_pc), .cfg_arch(cfg_arch),
        .wdog_limit(wdog_limit), .commit_valid(commit_valid),
        .mispredict(mispredict), .mispredict_pc(mispredict_pc),
        .watch_arch(watch_arch), .watch_data(watch_data),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_ch(snap_ch),
        .snap_data(snap_data), .snap_seq(snap_seq),
        .cycle_cnt(cycle_cnt), .commit_cnt(commit_cnt), .mispredict_cnt(mispredict_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow), .hang(hang)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          ch;
        logic [31:0] data;
        logic [31:0] seq;
    } ent_t;

    ent_t        m_q[$];
    longint      m_cyc, m_com, m_mis, m_drop;
    bit          m_ovf, m_hang, m_started;
    int          m_idle;
    bit          m_en[NCH];
    logic [31:0] m_pc[NCH];
    logic [4:0]  m_arch[NCH];

    function automatic longint sat(input longint v);
        return (v >= SAT) ? v : v + 1;
    endfunction

    always @(posedge clk) begin : model
        bit   pop;
        int   hit;
        ent_t e;
        if (!reset) begin
            m_q.delete();
            m_cyc = 0; m_com = 0; m_mis = 0; m_drop = 0;
            m_ovf = 0; m_hang = 0; m_started = 0; m_idle = 0;
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_pc[c] = 0; m_arch[c] = 0;
            end
        end else if (clear) begin
            m_q.delete();
            m_cyc = 0; m_com = 0; m_mis = 0; m_drop = 0;
            m_ovf = 0; m_hang = 0; m_started = 0; m_idle = 0;
        end else begin
            pop = (m_q.size() > 0) && snap_ready;
            hit = -1;
            for (int c = 0; c < NCH; c++)
                if (hit < 0 && mispredict && m_en[c] && m_pc[c] == mispredict_pc) hit = c;
            if (pop) void'(m_q.pop_front());
            if (hit >= 0) begin
                if (m_q.size() < DEP) begin
                    e.ch = hit; e.data = watch_data[hit*32 +: 32]; e.seq = m_mis[31:0];
                    m_q.push_back(e);
                end else begin
                    m_drop = sat(m_drop);
                    m_ovf  = 1;
                end
            end
            m_cyc = sat(m_cyc);
            if (commit_valid) m_com = sat(m_com);
            if (mispredict)   m_mis = sat(m_mis);
            // Watchdog: counts idle cycles since last commit once armed.
            if (!m_hang) begin
                if (commit_valid) begin
                    m_started = 1;
                    m_idle    = 0;
                end else if (m_started) begin
                    if (wdog_limit != 0 && m_idle == int'(wdog_limit) - 1) m_hang = 1;
                    else if (m_idle < 65535) m_idle++;
                end
            end
            if (cfg_we) begin
                m_en[cfg_ch] = cfg_en; m_pc[cfg_ch] = cfg_pc; m_arch[cfg_ch] = cfg_arch;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cycle_cnt", cycle_cnt, m_cyc[31:0]);
        chk("commit_cnt", commit_cnt, m_com[31:0]);
        chk("mispredict_cnt", mispredict_cnt, m_mis[31:0]);
        chk("drop_cnt", drop_cnt, m_drop[31:0]);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("hang", {31'd0, hang}, {31'd0, m_hang});
        chk("snap_valid", {31'd0, snap_valid}, {31'd0, (m_q.size() > 0)});
        if (m_q.size() > 0) begin
            chk("snap_ch", {30'd0, snap_ch}, m_q[0].ch);
            chk("snap_data", snap_data, m_q[0].data);
            chk("snap_seq", snap_seq, m_q[0].seq);
        end else if (!reset) begin
            chk("rst_snap_ch", {30'd0, snap_ch}, 32'd0);
            chk("rst_snap_data", snap_data, 32'd0);
            chk("rst_snap_seq", snap_seq, 32'd0);
        end
        for (int c = 0; c < NCH; c++)
            chk("watch_arch", {27'd0, watch_arch[c*5 +: 5]}, {27'd0, m_arch[c]});
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input bit en, input logic [31:0] pc, input logic [4:0] arch);
        cfg_we = 1'b1; cfg_ch = ch[1:0]; cfg_en = en; cfg_pc = pc; cfg_arch = arch;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic mp(input logic [31:0] pc);
        mispredict = 1'b1; mispredict_pc = pc;
        cyc();
        mispredict = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_en = 1'b0;
        cfg_pc = 32'd0; cfg_arch = 5'd0; wdog_limit = 16'd0; commit_valid = 1'b0;
        mispredict = 1'b0; mispredict_pc = 32'd0; snap_ready = 1'b0; watch_data = 128'd0;
        cyc(); cyc();
        chk("reset_cycle_cnt", cycle_cnt, 32'd0);
        chk("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
        chk("reset_hang", {31'd0, hang}, 32'd0);
        reset = 1'b1;

        // 1. counters
        for (int i = 0; i < 10; i++) begin
            commit_valid = (i % 3 == 0);
            cyc();
        end
        commit_valid = 1'b0;
        chk("t1_cycle_cnt", cycle_cnt, 32'd10);
        chk("t1_commit_cnt", commit_cnt, 32'd4);
        chk("t1_hang", {31'd0, hang}, 32'd0);

        // 2. capture
        cfg(0, 1'b1, 32'h68, 5'd20);
        cfg(2, 1'b1, 32'h78, 5'd18);
        watch_data = {32'h0000_0033, 32'd5, 32'h0000_0011, 32'hDEAD_0000};
        mp(32'h78);
        chk("t2_valid", {31'd0, snap_valid}, 32'd1);
        chk("t2_ch", {30'd0, snap_ch}, 32'd2);
        chk("t2_data", snap_data, 32'd5);
        chk("t2_seq", snap_seq, 32'd0);
        chk("t2_watch_arch2", {27'd0, watch_arch[14:10]}, 32'd18);
        snap_ready = 1'b1; cyc(); snap_ready = 1'b0;
        chk("t2_drained", {31'd0, snap_valid}, 32'd0);

        // 3. priority
        cfg(1, 1'b1, 32'hB8, 5'd7);
        cfg(3, 1'b1, 32'hB8, 5'd9);
        mp(32'hB8);
        chk("t3_ch", {30'd0, snap_ch}, 32'd1);
        chk("t3_seq", snap_seq, 32'd1);
        snap_ready = 1'b1; cyc(); snap_ready = 1'b0;
        chk("t3_one_entry", {31'd0, snap_valid}, 32'd0);

        // 4. overflow
        mispredict = 1'b1; mispredict_pc = 32'hB8;
        repeat (DEP + 2) cyc();
        mispredict = 1'b0;
        chk("t4_drop_cnt", drop_cnt, 32'd2);
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        snap_ready = 1'b1; mispredict = 1'b1;
        cyc();
        mispredict = 1'b0;
        chk("t4_full_pop_push", drop_cnt, 32'd2);
        n = 0;
        while (snap_valid && n < 20) begin
            cyc();
            n++;
        end
        snap_ready = 1'b0;
        chk("t4_entries", n, DEP);

        // 5. watchdog
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("t5_clear_cycle", cycle_cnt, 32'd0);
        chk("t5_clear_overflow", {31'd0, overflow}, 32'd0);
        wdog_limit = 16'd5; commit_valid = 1'b1; cyc(); commit_valid = 1'b0;
        repeat (4) cyc();
        chk("t5_hang_early", {31'd0, hang}, 32'd0);
        cyc();
        chk("t5_hang", {31'd0, hang}, 32'd1);
        commit_valid = 1'b1; cyc(); commit_valid = 1'b0;
        chk("t5_hang_sticky", {31'd0, hang}, 32'd1);
        clear = 1'b1; wdog_limit = 16'd0; cyc(); clear = 1'b0;
        commit_valid = 1'b1; cyc(); commit_valid = 1'b0;
        repeat (100) cyc();
        chk("t5_limit0", {31'd0, hang}, 32'd0);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("t5_clr_commit", commit_cnt, 32'd0);
        chk("t5_clr_mis", mispredict_cnt, 32'd0);
        chk("t5_cfg_kept0", {27'd0, watch_arch[4:0]}, 32'd20);
        chk("t5_cfg_kept2", {27'd0, watch_arch[14:10]}, 32'd18);
        mp(32'h78);
        chk("t5_cfg_kept_capture", {30'd0, snap_ch}, 32'd2);

        // 6. reset mid-drain
        mp(32'h78); mp(32'h78);
        reset = 1'b0; cyc();
        chk("t6_valid", {31'd0, snap_valid}, 32'd0);
        chk("t6_mis", mispredict_cnt, 32'd0);
        chk("t6_arch", {12'd0, watch_arch}, 32'd0);
        reset = 1'b1;
        mp(32'h78);
        chk("t6_disabled", {31'd0, snap_valid}, 32'd0);

        // Randomized phase, checked every cycle by the compare process.
        for (int i = 0; i < 2500; i++) begin
            watch_data    = {$urandom, $urandom, $urandom, $urandom};
            reset         = ($urandom_range(0, 299) != 0);
            clear         = ($urandom_range(0, 59) == 0);
            cfg_we        = !clear && ($urandom_range(0, 5) == 0);
            cfg_ch        = 2'($urandom_range(0, 3));
            cfg_en        = ($urandom_range(0, 3) != 0);
            cfg_pc        = 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
            cfg_arch      = 5'($urandom);
            if ($urandom_range(0, 99) == 0) wdog_limit = 16'($urandom_range(0, 6));
            commit_valid  = ($urandom_range(0, 5) == 0);
            mispredict    = ($urandom_range(0, 2) == 0);
            mispredict_pc = 32'h100 + 32'($urandom_range(0, 4)) * 32'd4;
            snap_ready    = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
